anfsqrt_seq: RTL
================

# anfsqrt_seq

Multi-cycle, shared square-root engine. Accepts 32-bit queries from `NREQ` requesters under round-robin arbitration and computes each 16-bit integer square root by stepping `UNROLL` instances of `anfsqrt_sqrtiu` repeatedly over registered att/eps/res state. It replaces the fully unrolled `anfsqrt_sqrt` wherever area matters more than latency. Each result is bit-identical to `anfsqrt_sqrt` for the same query.

## Interface
- `NREQ`, 2: number of requesters, ≥1.
- `UNROLL`, 1: `anfsqrt_sqrtiu` stages applied per cycle; must divide 32 (1, 2, 4, 8, 16, 32).
- `IDW`, `$clog2(NREQ)` (min 1): width of the response ID.

Ports:
- `clk` in 1: clock.
- `rst` in 1: **one clock; reset is asynchronous and active-high.**
- `req_valid` in `NREQ`: per-requester query valid.
- `req_query` in `32*NREQ`: query of requester k at bits `[32k+31:32k]`.
- `req_ready` out `NREQ`: one-hot grant/accept.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_result` out 16: floor square root.
- `rsp_id` out `IDW`: index of the requester whose query produced `rsp_result`.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - If any `req_valid` is high: winner = first set bit at or after `rr_ptr`, wrapping.
  - `req_ready[winner]` is driven combinationally in the same cycle; all other ready bits are 0.
  - On the edge: load att=65536, res=0, eps=`req_query[winner]`; store the ID; set `rr_ptr` = (winner+1) mod `NREQ`; clear the iteration counter; go to RUN.
  - If no `req_valid`: stay in IDLE, all `req_ready`=0.
- **RUN**
  - Each edge: att/eps/res ← output of `UNROLL` chained `anfsqrt_sqrtiu`, fed by the registers.
  - Counter increments each edge. After `32/UNROLL` RUN edges: go to DONE, register `rsp_result`=res[15:0].
- **DONE**
  - `rsp_valid`=1. `rsp_result` and `rsp_id` are held stable until the handshake.
  - On `rsp_valid && rsp_ready`: go to IDLE.
  - `req_ready` is 0 in RUN and in DONE.
- Width rules: att/eps/res registers are 32 bits. The result is the low 16 bits of res; there is no saturation or rounding.
- `req_valid` may drop without a handshake. No request is latched until its `req_ready` handshake.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, counter=0, `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_id`=0, datapath registers 0.
- Latency: accept at edge T; `rsp_valid` rises after edge T+32/UNROLL (32 cycles for `UNROLL`=1, 1 cycle for `UNROLL`=32).
- Throughput: with `rsp_ready` tied high, one result per 32/UNROLL+2 cycles (RUN, DONE, IDLE).
- Simultaneous requests: exactly one is granted per IDLE cycle. The others wait. Pending requesters are served in round-robin order, so each waits at most `NREQ`−1 jobs.
- Response backpressure: DONE holds indefinitely. No new query is accepted during the hold.
- Reset mid-operation (RUN or DONE): the job is discarded and no response is emitted. The block returns to IDLE with `rr_ptr`=0.
- Query input is sampled only at the accept edge. Later changes to `req_query` do not affect the job.

## Structure
- Shared package `anfsqrt_pkg`: constants `ANFSQRT_ITERS`=32, `ANFSQRT_ATT_INIT`=65536, and the FSM state encoding.
- One natural sub-module, `anfsqrt_rr_arb`: NREQ-wide round-robin picker, combinational, with the pointer as an input.
- The `UNROLL` `anfsqrt_sqrtiu` instances are a generate chain inside `anfsqrt_seq`.

## Test plan
- Single requester, `UNROLL`=1, queries 0, 144, 1000000, 0xFFFFFFFF → `rsp_result` 0, 12, 1000, 65535. `rsp_valid` rises exactly 32 cycles after each accept.
- Both requesters valid continuously with `rr_ptr`=0 after reset, queries 4 and 9 → grants alternate 0,1,0,1. Responses are (2, id0), (3, id1), repeating.
- `rsp_ready` held low for 10 cycles in DONE → `rsp_result`/`rsp_id` stable, `req_ready` stays 0. The next accept occurs one cycle after the handshake.
- `rst` asserted 10 cycles into RUN → no `rsp_valid`, all outputs 0. After release, a new query 81 yields 9.
- `UNROLL`=4 and `UNROLL`=32: 1000 random queries → results match `anfsqrt_sqrt` and floor(sqrt(q)). Latency is 8 and 1 cycles respectively.

Source files
------------

// File: rtl/anfsqrt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : anfsqrt_pkg                                               |
// | Purpose  : Shared constants and FSM encoding for the sequential      |
// |            square-root engine.                                       |
// | Contents : ANFSQRT_ITERS, ANFSQRT_ATT_INIT, ANFSQRT_PHASE_BIT,       |
// |            state_e                                                   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package anfsqrt_pkg;

  // Number of anfsqrt_sqrtiu steps that make up one complete root.
  localparam int          ANFSQRT_ITERS    = 32;
  // Initial value of the att register when a job is accepted.
  localparam logic [31:0] ANFSQRT_ATT_INIT = 32'd65536;
  // att bit used by anfsqrt_sqrtiu to alternate between its prepare and
  // decide half-steps; a root bit is resolved on every second step.
  localparam int          ANFSQRT_PHASE_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/anfsqrt_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : anfsqrt_rr_arb                                            |
// | Purpose  : Combinational round-robin picker: first set request at or |
// |            after ptr_i, wrapping around NREQ.                        |
// | Ports    : req_i  in  NREQ  request vector                           |
// |            ptr_i  in  IDW   highest-priority index                   |
// |            gnt_o  out NREQ  one-hot grant (0 when no request)        |
// |            idx_o  out IDW   index of the granted requester           |
// |            any_o  out 1     at least one request present             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module anfsqrt_rr_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  logic [IDW-1:0] cand;

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_add(ptr_i, k);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    gnt_o = any_o ? (NREQ'(1) << idx_o) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/anfsqrt_sqrtiu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : anfsqrt_sqrtiu                                            |
// | Purpose  : One combinational square-root iteration over att/eps/res. |
// |            eps always holds (query - res*res). Steps alternate:      |
// |            a prepare step marks att[31]; a decide step tries the     |
// |            root bit b = att[30:0]/2 and keeps it when it still fits. |
// |            Starting from att=65536, 32 steps resolve bits 15..0.     |
// | Ports    : att_i/eps_i/res_i  in  32  current state                  |
// |            att_o/eps_o/res_o  out 32  state after this step          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module anfsqrt_sqrtiu
  import anfsqrt_pkg::*;
(
  input  logic [31:0] att_i,
  input  logic [31:0] eps_i,
  input  logic [31:0] res_i,
  output logic [31:0] att_o,
  output logic [31:0] eps_o,
  output logic [31:0] res_o
);

  logic [31:0] trial_bit;
  logic [32:0] term;
  logic        fits;

  always_comb begin
    att_o     = att_i;
    eps_o     = eps_i;
    res_o     = res_i;
    trial_bit = {1'b0, att_i[30:0]} >> 1;
    // (res+b)^2 - res^2 = 2*res*b + b*b; b is one-hot so both products are
    // shifts. res only has bits above b, so the sum stays below 2^33.
    term      = {1'b0, res_i} * {trial_bit, 1'b0} + {1'b0, trial_bit} * {1'b0, trial_bit};
    fits      = ({1'b0, eps_i} >= term);
    if (!att_i[ANFSQRT_PHASE_BIT]) begin
      att_o = att_i | (32'd1 << ANFSQRT_PHASE_BIT);
    end else begin
      att_o = trial_bit;
      if (fits) begin
        eps_o = eps_i - term[31:0];
        res_o = res_i | trial_bit;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/anfsqrt_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : anfsqrt_seq                                               |
// | Purpose  : Shared multi-cycle 32-bit integer square-root engine with |
// |            round-robin intake from NREQ requesters. UNROLL sqrtiu    |
// |            stages are applied per RUN cycle.                         |
// | Ports    : clk         in  1        clock                            |
// |            rst         in  1        async active-high reset          |
// |            req_valid   in  NREQ     per-requester query valid        |
// |            req_query   in  32*NREQ  query k at [32k+31:32k]          |
// |            req_ready   out NREQ     one-hot accept (IDLE only)       |
// |            rsp_valid   out 1        result valid (DONE)              |
// |            rsp_ready   in  1        consumer accepts result          |
// |            rsp_result  out 16       floor square root                |
// |            rsp_id      out IDW      requester that issued the query  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module anfsqrt_seq
  import anfsqrt_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int UNROLL = 1,
  parameter int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_query,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [15:0]          rsp_result,
  output logic [IDW-1:0]       rsp_id
);

  localparam int         STEPS     = ANFSQRT_ITERS / UNROLL;
  localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [5:0]     ctr_q, ctr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [31:0]    att_q, att_d;
  logic [31:0]    eps_q, eps_d;
  logic [31:0]    res_q, res_d;
  logic [15:0]    result_q, result_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  win;
  logic            any_req;
  logic [31:0]     win_query;

  anfsqrt_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (win),
    .any_o (any_req)
  );

  always_comb begin
    win_query = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (IDW'(k) == win) win_query = req_query[32*k +: 32];
    end
  end

  // Iteration chain: stage 0 is fed by the registers, the last stage's
  // outputs are what RUN loads back.
  logic [31:0] att_c [0:UNROLL];
  logic [31:0] eps_c [0:UNROLL];
  logic [31:0] res_c [0:UNROLL];

  assign att_c[0] = att_q;
  assign eps_c[0] = eps_q;
  assign res_c[0] = res_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_stage
    anfsqrt_sqrtiu u_iu (
      .att_i (att_c[g]),
      .eps_i (eps_c[g]),
      .res_i (res_c[g]),
      .att_o (att_c[g+1]),
      .eps_o (eps_c[g+1]),
      .res_o (res_c[g+1])
    );
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    ctr_d     = ctr_q;
    id_d      = id_q;
    att_d     = att_q;
    eps_d     = eps_q;
    res_d     = res_q;
    result_d  = result_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          req_ready = gnt;
          att_d     = ANFSQRT_ATT_INIT;
          res_d     = '0;
          eps_d     = win_query;
          id_d      = win;
          rr_ptr_d  = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
          ctr_d     = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        att_d = att_c[UNROLL];
        eps_d = eps_c[UNROLL];
        res_d = res_c[UNROLL];
        ctr_d = ctr_q + 6'd1;
        if (ctr_q == LAST_STEP) begin
          result_d = res_c[UNROLL][15:0];
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      ctr_q    <= '0;
      id_q     <= '0;
      att_q    <= '0;
      eps_q    <= '0;
      res_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      ctr_q    <= ctr_d;
      id_q     <= id_d;
      att_q    <= att_d;
      eps_q    <= eps_d;
      res_q    <= res_d;
      result_q <= result_d;
    end
  end

  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_result = result_q;
  assign rsp_id     = id_q;

endmodule
`default_nettype wire
